// File: rtl/fp16_mul_core.sv
// ----------------------------------------------------------------------------
// fp16_mul_core
//   IEEE 754 binary16 multiplier. The product is rounded to nearest, ties to
//   even, and subnormal operands and results are fully supported. A
//   combinational core feeds a single output register, giving 1-cycle
//   latency and one result per cycle.
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset; clears result and both flags
//   a, b      : binary16 operands, sampled on every rising clk edge
//   result    : registered binary16 product
//   underflow : registered underflow flag; the product was tiny before
//               rounding and the rounding was inexact
//   overflow  : registered overflow flag; the product rounded to +/-inf
//
// There is no handshake: a and b are taken on every edge, and the outputs
// hold until the next edge.
// ----------------------------------------------------------------------------
module fp16_mul_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic        underflow,
    output logic        overflow
);

    // ---------------- operand decode ----------------
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        sign;
    logic [10:0] ma, mb;
    logic signed [7:0] ea, eb;

    always_comb begin
        a_zero = (a[14:10] == 5'd0)  && (a[9:0] == 10'd0);
        b_zero = (b[14:10] == 5'd0)  && (b[9:0] == 10'd0);
        a_inf  = (a[14:10] == 5'd31) && (a[9:0] == 10'd0);
        b_inf  = (b[14:10] == 5'd31) && (b[9:0] == 10'd0);
        a_nan  = (a[14:10] == 5'd31) && (a[9:0] != 10'd0);
        b_nan  = (b[14:10] == 5'd31) && (b[9:0] != 10'd0);
        sign   = a[15] ^ b[15];
        // A subnormal has a hidden bit of 0 and the same exponent (-14) as
        // the smallest normal value.
        ma = {(a[14:10] != 5'd0), a[9:0]};
        mb = {(b[14:10] != 5'd0), b[9:0]};
        ea = (a[14:10] == 5'd0) ? -8'sd14 : $signed({3'b000, a[14:10]}) - 8'sd15;
        eb = (b[14:10] == 5'd0) ? -8'sd14 : $signed({3'b000, b[14:10]}) - 8'sd15;
    end

    // ---------------- finite x finite datapath ----------------
    logic [21:0] prod, pn, shifted;
    logic [4:0]  lz;
    logic signed [7:0] e_unb;
    logic [7:0]  sh_raw;
    logic [4:0]  sh;
    logic        tiny, lost, guard, sticky, round_up, carry;
    logic [10:0] mant;
    logic [11:0] mant_r;
    logic signed [7:0] exp_b;
    logic [15:0] fin_result;
    logic        fin_uf, fin_of;

    always_comb begin
        prod = 22'(ma) * 22'(mb);

        // Count leading zeros so the product (possibly from subnormal
        // operands) can be normalised to a leading 1 at bit 21.
        lz = 5'd0;
        for (int i = 0; i < 22; i++) begin
            if (prod[i]) lz = 5'(21 - i);
        end
        pn = prod << lz;

        // pn holds 1.xxx at bits [21:0], so the value is 1.xxx * 2^e_unb.
        e_unb = ea + eb + 8'sd1 - $signed({3'b000, lz});

        // A tiny result (exponent below -14) is shifted right into subnormal
        // position. Shifts of 23 or more leave nothing, and everything goes
        // to sticky.
        tiny   = (e_unb < -8'sd14);
        sh_raw = tiny ? 8'(-8'sd14 - e_unb) : 8'd0;
        sh     = (sh_raw > 8'd23) ? 5'd23 : sh_raw[4:0];
        shifted = pn >> sh;
        lost    = ((shifted << sh) != pn);

        mant     = shifted[21:11];
        guard    = shifted[10];
        sticky   = (shifted[9:0] != 10'd0) || lost;
        round_up = guard && (sticky || mant[0]);
        mant_r   = {1'b0, mant} + {11'd0, round_up};
        carry    = mant_r[11];

        fin_of = 1'b0;
        fin_uf = 1'b0;
        exp_b  = 8'sd0;
        if (tiny) begin
            // A subnormal that rounds up to 2^-14 sets bit 10, which lands
            // in the exponent field as exp=1. A round to zero yields signed
            // zero.
            fin_result = {sign, 4'b0000, mant_r[10], mant_r[9:0]};
            fin_uf     = guard || sticky;
        end else begin
            // On a carry-out mant_r is 0x800, so the fraction bits are
            // already zero and only the exponent moves.
            exp_b = e_unb + 8'sd15 + {7'd0, carry};
            if (exp_b >= 8'sd31) begin
                fin_result = {sign, 5'h1F, 10'd0};
                fin_of     = 1'b1;
            end else begin
                fin_result = {sign, exp_b[4:0], mant_r[9:0]};
            end
        end
    end

    // ---------------- special-case selection ----------------
    logic [15:0] next_result;
    logic        next_uf, next_of;

    always_comb begin
        next_result = fin_result;
        next_uf     = fin_uf;
        next_of     = fin_of;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            next_result = 16'h7E00;
            next_uf     = 1'b0;
            next_of     = 1'b0;
        end else if (a_inf || b_inf) begin
            next_result = {sign, 5'h1F, 10'd0};
            next_uf     = 1'b0;
            next_of     = 1'b0;
        end else if (a_zero || b_zero) begin
            next_result = {sign, 15'd0};
            next_uf     = 1'b0;
            next_of     = 1'b0;
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= 16'h0000;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            result    <= next_result;
            underflow <= next_uf;
            overflow  <= next_of;
        end
    end

endmodule

// File: tb/tb_fp16_mul_core.sv
// ----------------------------------------------------------------------------
// tb_fp16_mul_core
//   Directed bench for fp16_mul_core. Each vector gives two operands and the
//   expected {result, underflow, overflow}, all worked out by hand.
// ----------------------------------------------------------------------------
module tb_fp16_mul_core;

    logic        clk;
    logic        rst_n;
    logic [15:0] a, b;
    logic [15:0] result;
    logic        underflow, overflow;

    int checks = 0;
    int errors = 0;

    fp16_mul_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .result    (result),
        .underflow (underflow),
        .overflow  (overflow)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    // The value is packed as {result[15:0], underflow, overflow}.
    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got res=%h uf=%b of=%b, expected res=%h uf=%b of=%b",
                     tag, got[17:2], got[1], got[0], exp[17:2], exp[1], exp[0]);
        end
    endtask

    // Drive the operands on the falling edge, let one rising edge pass, then
    // sample the outputs 1 ns later.
    task automatic apply(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] er, input logic euf, input logic eof);
        @(negedge clk);
        a = va;
        b = vb;
        @(posedge clk);
        #1;
        check(tag, {result, underflow, overflow}, {er, euf, eof});
    endtask

    initial begin
        rst_n = 1'b0;
        a = 16'h3C00;
        b = 16'h3C00;

        // Reset holds the outputs at zero, even across clock edges.
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", {result, underflow, overflow}, 18'h0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("one_x_one", {result, underflow, overflow}, {16'h3C00, 1'b0, 1'b0});

        // Normal arithmetic
        apply("two_x_three",  16'h4000, 16'h4200, 16'h4600, 1'b0, 1'b0);
        apply("neg_1p5_x_2",  16'hBE00, 16'h4000, 16'hC200, 1'b0, 1'b0);
        apply("rne_sq",       16'h3C01, 16'h3C01, 16'h3C02, 1'b0, 1'b0);
        apply("one_x_1ulp",   16'h3C00, 16'h3C01, 16'h3C01, 1'b0, 1'b0);

        // Overflow
        apply("ovf_pos",      16'h7BFF, 16'h4000, 16'h7C00, 1'b0, 1'b1);
        apply("ovf_neg",      16'hF800, 16'h4000, 16'hFC00, 1'b0, 1'b1);

        // Subnormal results and underflow
        apply("uf_tie_zero",  16'h0001, 16'h3800, 16'h0000, 1'b1, 1'b0);
        apply("exact_subn",   16'h0400, 16'h3800, 16'h0200, 1'b0, 1'b0);
        apply("subn_to_norm", 16'h0200, 16'h4000, 16'h0400, 1'b0, 1'b0);
        apply("round_to_min", 16'h03FF, 16'h3C01, 16'h0400, 1'b1, 1'b0);
        apply("subn_x_subn",  16'h8001, 16'h0001, 16'h8000, 1'b1, 1'b0);

        // Specials
        apply("inf_x_zero",   16'h7C00, 16'h0000, 16'h7E00, 1'b0, 1'b0);
        apply("nan_in",       16'h7E01, 16'h3C00, 16'h7E00, 1'b0, 1'b0);
        apply("ninf_x_2",     16'hFC00, 16'h4000, 16'hFC00, 1'b0, 1'b0);
        apply("nzero_x_1",    16'h8000, 16'h3C00, 16'h8000, 1'b0, 1'b0);
        apply("inf_x_ninf",   16'h7C00, 16'hFC00, 16'hFC00, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle
        apply("pre_reset",    16'h4000, 16'h4200, 16'h4600, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", {result, underflow, overflow}, 18'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_reset",   16'h4000, 16'h4000, 16'h4400, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net in case the stimulus stalls.
    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: got no end of stimulus, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp16_mul_core.md
Name: fp16_mul_core

Overview:
- IEEE 754 binary16 (half-precision) multiplier with one registered output stage.
- Computes result = a × b, rounded to nearest, ties to even, with full subnormal support, and raises underflow/overflow flags.
- Used as the FP16 multiply stage of the INT/FP MAC datapath.
- Fixed function, so there are no parameters.

Parameters:
- none

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  16  operand 1, fields sign[15], exp[14:10], frac[9:0]
- b  input  16  operand 2, same format
- result  output  16  registered binary16 product
- underflow  output  1  registered underflow flag for this result
- overflow  output  1  registered overflow flag for this result

Behaviour:
- Reset: one clock, asynchronous active-low reset.
  - While rst_n=0: result=16'h0000, underflow=0, overflow=0.
  - Reset asserted mid-operation clears the outputs immediately; no pending result survives.
- Timing: a combinational core feeds one output register.
  - a and b are sampled on every rising clk edge.
  - result and the flags for those operands appear right after that edge, so latency is 1 cycle and throughput is 1 per cycle.
  - There is no handshake and no valid signal; outputs hold until the next edge.
- Sign: sign = a[15] XOR b[15] for all non-NaN results.
- Operand decode, per operand:
  - exp=0 and frac=0: zero.
  - exp=0 and frac≠0: subnormal, significand 0.frac, effective exponent -14.
  - exp=1..30: normal, significand 1.frac, exponent exp-15.
  - exp=31 and frac=0: infinity.
  - exp=31 and frac≠0: NaN.
- Special cases, which set both flags to 0:
  - Any NaN input, or infinity × zero: result=16'h7E00 (canonical quiet NaN, sign 0).
  - Infinity × nonzero finite, or infinity × infinity: signed infinity (exp=31, frac=0).
  - Zero × finite: signed zero.
- Finite × finite datapath:
  - 11×11-bit significand multiply gives a 22-bit product.
  - Normalize the product, using a leading-zero count so subnormal operands are handled.
  - Unbiased exponent = ea + eb.
  - Round to 11 significant bits with guard, round and sticky bits (RNE).
  - If rounding carries out, renormalize and increment the exponent.
- Overflow:
  - Condition: the rounded biased exponent is ≥ 31.
  - Response: result = signed infinity and overflow=1.
- Subnormal and underflow:
  - If the unbiased exponent is < -14, right-shift the significand into subnormal position, OR-ing all shifted-out bits into sticky, then apply RNE.
  - A subnormal result that rounds up to 2^-14 is encoded as the normal value exp=1, frac=0.
  - A result that rounds to zero is encoded as signed zero.
  - underflow=1 when the exact product is nonzero and tiny (|exact| < 2^-14, tininess detected before rounding) and the rounding was inexact.
  - Otherwise underflow=0.
- overflow and underflow are never 1 together.
- Exact cases (no rounding error) never raise underflow.

Test Plan:
- Reset: hold rst_n=0 with a=16'h3C00, b=16'h3C00 -> result=16'h0000, both flags 0. Release reset, then one clk edge -> result=16'h3C00 (1.0 × 1.0).
- Normal arithmetic, one input pair per cycle, each with 1-cycle latency:
  - 16'h4000 × 16'h4200 -> 16'h4600 (2 × 3 = 6).
  - 16'hBE00 × 16'h4000 -> 16'hC200 (-1.5 × 2 = -3).
  - 16'h3C01 × 16'h3C01 -> 16'h3C02 (RNE applied).
- Overflow: 16'h7BFF × 16'h4000 -> result=16'h7C00, overflow=1, underflow=0.
- Underflow:
  - 16'h0001 × 16'h3800: the product 2^-25 is an exact tie -> result=16'h0000, underflow=1.
  - 16'h0400 × 16'h3800 -> result=16'h0200, underflow=0 (exact subnormal).
- Specials:
  - 16'h7C00 × 16'h0000 -> 16'h7E00.
  - 16'h7E01 × 16'h3C00 -> 16'h7E00.
  - 16'hFC00 × 16'h4000 -> 16'hFC00.
  - 16'h8000 × 16'h3C00 -> 16'h8000.
  - All of these with both flags 0.
- Reset mid-stream: assert rst_n low asynchronously between clk edges while result is nonzero -> outputs clear at once, without waiting for a clk edge.
